// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states, grant codes and
// write-buffer entry field layout.
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StGntI    = 3'd1,
        StGntD    = 3'd2,
        StGntW    = 3'd3,
        StRecover = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        GntNone   = 2'd0,
        GntIcache = 2'd1,
        GntDcache = 2'd2,
        GntWbuf   = 2'd3
    } grant_e;

    // Write-buffer entry is {addr, data[31:0], be[3:0]}
    localparam int unsigned WbAddrLsb = 36;
    localparam int unsigned WbDataLsb = 4;
    localparam int unsigned WbDataW   = 32;
    localparam int unsigned WbBeW     = 4;

    // Refill lines are 32 bytes
    localparam int unsigned LineOffW  = 5;

    localparam logic PtrFavourData  = 1'b0;

endpackage

// File: rtl/mem_bus_arbiter_rr_pointer.sv
// One-bit round-robin tracker between instruction and data sides.
// Output high means the instruction side wins a tie.
module mem_bus_arbiter_rr_pointer
    import mem_bus_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_advance,
    output logic o_favour_instr
);

    logic r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PtrFavourData;
        end else if (i_advance) begin
            r_ptr <= ~r_ptr;
        end
    end

    assign o_favour_instr = r_ptr;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between icache refills, dcache refills and
// write-buffer drains; the write buffer always drains ahead of dcache reads.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned WB_W   = 68
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_req_in,
    input  logic [ADDR_W-1:0] icache_addr_in,
    output logic              icache_ready_out,
    output logic [LINE_W-1:0] icache_rdata_out,
    input  logic              dcache_req_in,
    input  logic [ADDR_W-1:0] dcache_addr_in,
    output logic              dcache_ready_out,
    output logic [LINE_W-1:0] dcache_rdata_out,
    input  logic              wb_empty_in,
    input  logic [WB_W-1:0]   wb_data_in,
    output logic              wb_pop_en_out,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [31:0]       mem_wdata_out,
    output logic [3:0]        mem_be_out,
    input  logic              mem_ready_in,
    input  logic [LINE_W-1:0] mem_rdata_in,
    output logic [1:0]        grant_out
);

    state_e              r_state;
    state_e              w_state_next;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [WbDataW-1:0]  r_wdata;
    logic [WbBeW-1:0]    r_be;

    logic                w_load;
    logic                w_we_next;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [WbDataW-1:0]  w_wdata_next;
    logic [WbBeW-1:0]    w_be_next;

    logic                w_in_gnt;
    logic                w_done;
    logic                w_favour_instr;
    logic                w_data_cand;
    logic [ADDR_W-1:0]   w_line_mask;
    logic [ADDR_W-1:0]   w_wb_addr;
    logic                w_icache_ready;
    logic                w_dcache_ready;

    assign w_line_mask = {{(ADDR_W - LineOffW){1'b1}}, {LineOffW{1'b0}}};
    assign w_wb_addr   = ADDR_W'(wb_data_in[WB_W-1:WbAddrLsb]);
    assign w_data_cand = !wb_empty_in || dcache_req_in;
    assign w_in_gnt    = (r_state == StGntI) || (r_state == StGntD) || (r_state == StGntW);
    assign w_done      = w_in_gnt && mem_ready_in;

    mem_bus_arbiter_rr_pointer u_rr_pointer (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_advance      (w_done),
        .o_favour_instr (w_favour_instr)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_we_next    = 1'b0;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_be_next    = r_be;
        case (r_state)
            StIdle: begin
                // A pending write always shadows the dcache read on the data side
                if (w_data_cand && (!icache_req_in || !w_favour_instr)) begin
                    w_load = 1'b1;
                    if (!wb_empty_in) begin
                        w_state_next = StGntW;
                        w_we_next    = 1'b1;
                        w_addr_next  = w_wb_addr;
                        w_wdata_next = wb_data_in[WbAddrLsb-1:WbDataLsb];
                        w_be_next    = wb_data_in[WbBeW-1:0];
                    end else begin
                        w_state_next = StGntD;
                        w_addr_next  = dcache_addr_in & w_line_mask;
                    end
                end else if (icache_req_in) begin
                    w_load       = 1'b1;
                    w_state_next = StGntI;
                    w_addr_next  = icache_addr_in & w_line_mask;
                end
            end
            StGntI, StGntD, StGntW: begin
                if (mem_ready_in) begin
                    w_state_next = StRecover;
                end
            end
            StRecover: w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_we    <= w_we_next;
                r_addr  <= w_addr_next;
                r_wdata <= w_wdata_next;
                r_be    <= w_be_next;
            end
        end
    end

    assign w_icache_ready = (r_state == StGntI) && mem_ready_in;
    assign w_dcache_ready = (r_state == StGntD) && mem_ready_in;

    assign icache_ready_out = w_icache_ready;
    assign dcache_ready_out = w_dcache_ready;
    assign wb_pop_en_out    = (r_state == StGntW) && mem_ready_in;
    assign icache_rdata_out = w_icache_ready ? mem_rdata_in : '0;
    assign dcache_rdata_out = w_dcache_ready ? mem_rdata_in : '0;

    assign mem_req_out   = w_in_gnt;
    assign mem_we_out    = r_we;
    assign mem_addr_out  = r_addr;
    assign mem_wdata_out = r_wdata;
    assign mem_be_out    = r_be;

    always_comb begin
        grant_out = GntNone;
        case (r_state)
            StGntI:  grant_out = GntIcache;
            StGntD:  grant_out = GntDcache;
            StGntW:  grant_out = GntWbuf;
            default: grant_out = GntNone;
        endcase
    end

endmodule
